// File: rtl/cpu_pkg.sv
// Purpose: shared definitions for the multi-cycle CPU: opcodes, FSM states,
//          ALU selects, instruction field layout and a register-field check.
// Ports:   none (package).
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned FIELD_W = 8;

  localparam logic [FIELD_W-1:0] OP_LOADI = 8'h00;
  localparam logic [FIELD_W-1:0] OP_MOV   = 8'h01;
  localparam logic [FIELD_W-1:0] OP_ADD   = 8'h02;
  localparam logic [FIELD_W-1:0] OP_SUB   = 8'h03;
  localparam logic [FIELD_W-1:0] OP_AND   = 8'h04;
  localparam logic [FIELD_W-1:0] OP_OR    = 8'h05;
  localparam logic [FIELD_W-1:0] OP_J     = 8'h06;
  localparam logic [FIELD_W-1:0] OP_BEQ   = 8'h07;

  typedef enum logic [1:0] {
    ST_FETCH     = 2'd0,
    ST_DECODE    = 2'd1,
    ST_EXECUTE   = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ALU_FWD = 2'd0,
    ALU_ADD = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  // Instruction word layout: OP[31:24], RD/OFFSET[23:16], RT[15:8], RS/IMM[7:0].
  typedef struct packed {
    logic [FIELD_W-1:0] op;
    logic [FIELD_W-1:0] rd;
    logic [FIELD_W-1:0] rt;
    logic [FIELD_W-1:0] rs;
  } instr_t;

  // True when a register field has no bits set above the index width.
  function automatic logic field_ok(input logic [FIELD_W-1:0] f, input int unsigned aw);
    if (aw >= FIELD_W) return 1'b1;
    return (f >> aw) == '0;
  endfunction

endpackage

// File: rtl/cpu_multicycle_reg_file_p.sv
// Purpose: general register file, two combinational read ports, one debug
//          read port, one synchronous write port, synchronous clear.
// Ports:   i_clk, i_reset (sync, active-high); i_raddr_a/o_rdata_a,
//          i_raddr_b/o_rdata_b operand reads; i_dbg_addr/o_dbg_data debug
//          read; i_we/i_waddr/i_wdata write port.
module reg_file_p #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREG   = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [$clog2(NREG)-1:0]  i_raddr_a,
  output logic [DATA_W-1:0]        o_rdata_a,
  input  logic [$clog2(NREG)-1:0]  i_raddr_b,
  output logic [DATA_W-1:0]        o_rdata_b,
  input  logic [$clog2(NREG)-1:0]  i_dbg_addr,
  output logic [DATA_W-1:0]        o_dbg_data,
  input  logic                     i_we,
  input  logic [$clog2(NREG)-1:0]  i_waddr,
  input  logic [DATA_W-1:0]        i_wdata
);

  logic [DATA_W-1:0] r_regs [NREG];

  // Reset clear takes priority over a write on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < int'(NREG); i++) r_regs[i] <= '0;
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = r_regs[i_raddr_a];
  assign o_rdata_b  = r_regs[i_raddr_b];
  assign o_dbg_data = r_regs[i_dbg_addr];

endmodule

// File: rtl/cpu_multicycle.sv
// Purpose: parametrised multi-cycle CPU core, FETCH/DECODE/EXECUTE/WRITEBACK.
// Ports:   CLK, RESET (sync, active-high); PC current instruction address;
//          IMEM_READ fetch request; IMEM_BUSYWAIT fetch stall; INSTRUCTION
//          fetched word; ILLEGAL one-cycle pulse in WRITEBACK of an illegal
//          instruction; DBG_ADDR/DBG_DATA combinational register peek.
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREG   = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  output logic [31:0]             PC,
  output logic                    IMEM_READ,
  input  logic                    IMEM_BUSYWAIT,
  input  logic [INSTR_W-1:0]      INSTRUCTION,
  output logic                    ILLEGAL,
  input  logic [$clog2(NREG)-1:0] DBG_ADDR,
  output logic [DATA_W-1:0]       DBG_DATA
);

  localparam int unsigned REG_AW = $clog2(NREG);

  state_e            r_state, w_next_state;
  instr_t            r_ir;
  logic [DATA_W-1:0] r_a, r_b, r_result;
  logic [31:0]       r_pc, r_target;
  alu_op_e           r_alu_op;
  logic              r_sub, r_use_imm, r_writes, r_is_j, r_is_beq, r_illegal_ins;
  logic              r_eq, r_illegal, r_imem_read;

  alu_op_e           w_alu_op;
  logic              w_sub, w_use_imm, w_writes, w_is_j, w_is_beq, w_legal;
  logic [DATA_W-1:0] w_rdata_a, w_rdata_b, w_imm_ext, w_opb, w_alu;
  logic [31:0]       w_target;
  logic              w_we;

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= ST_FETCH;
    else       r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH:     if (!IMEM_BUSYWAIT) w_next_state = ST_DECODE;
      ST_DECODE:    w_next_state = ST_EXECUTE;
      ST_EXECUTE:   w_next_state = ST_WRITEBACK;
      ST_WRITEBACK: w_next_state = ST_FETCH;
      default:      w_next_state = ST_FETCH;
    endcase
  end

  // Opcode classification; an illegal instruction degrades to a NOP.
  always_comb begin
    w_alu_op  = ALU_FWD;
    w_sub     = 1'b0;
    w_use_imm = 1'b0;
    w_writes  = 1'b0;
    w_is_j    = 1'b0;
    w_is_beq  = 1'b0;
    w_legal   = 1'b1;
    case (r_ir.op)
      OP_LOADI: begin
        w_use_imm = 1'b1;
        w_writes  = 1'b1;
        w_legal   = field_ok(r_ir.rd, REG_AW);
      end
      OP_MOV: begin
        w_writes = 1'b1;
        w_legal  = field_ok(r_ir.rd, REG_AW) & field_ok(r_ir.rs, REG_AW);
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        w_writes = 1'b1;
        w_legal  = field_ok(r_ir.rd, REG_AW) & field_ok(r_ir.rt, REG_AW)
                 & field_ok(r_ir.rs, REG_AW);
        case (r_ir.op)
          OP_ADD:  w_alu_op = ALU_ADD;
          OP_SUB:  begin w_alu_op = ALU_ADD; w_sub = 1'b1; end
          OP_AND:  w_alu_op = ALU_AND;
          default: w_alu_op = ALU_OR;
        endcase
      end
      OP_J:   w_is_j = 1'b1;
      OP_BEQ: begin
        w_is_beq = 1'b1;
        w_legal  = field_ok(r_ir.rt, REG_AW) & field_ok(r_ir.rs, REG_AW);
      end
      default: w_legal = 1'b0;
    endcase
    if (!w_legal) begin
      w_writes = 1'b0;
      w_is_j   = 1'b0;
      w_is_beq = 1'b0;
    end
  end

  // Immediate mux, negation for sub, and the ALU.
  assign w_imm_ext = DATA_W'($signed(r_ir.rs));
  assign w_opb     = r_use_imm ? w_imm_ext : (r_sub ? (~r_b + DATA_W'(1)) : r_b);

  always_comb begin
    w_alu = w_opb;
    case (r_alu_op)
      ALU_FWD: w_alu = w_opb;
      ALU_ADD: w_alu = r_a + w_opb;
      ALU_AND: w_alu = r_a & r_b;
      ALU_OR:  w_alu = r_a | r_b;
      default: w_alu = w_opb;
    endcase
  end

  // Branch target: PC + 4 + sext(OFFSET) * 4, wrapping modulo 2^32.
  assign w_target = r_pc + 32'd4 + 32'($signed({r_ir.rd, 2'b00}));

  // Datapath registers, advanced per state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pc          <= '0;
      r_ir          <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_result      <= '0;
      r_target      <= '0;
      r_eq          <= 1'b0;
      r_alu_op      <= ALU_FWD;
      r_sub         <= 1'b0;
      r_use_imm     <= 1'b0;
      r_writes      <= 1'b0;
      r_is_j        <= 1'b0;
      r_is_beq      <= 1'b0;
      r_illegal_ins <= 1'b0;
      r_illegal     <= 1'b0;
      r_imem_read   <= 1'b1;
    end else begin
      r_imem_read <= (w_next_state == ST_FETCH);
      r_illegal   <= 1'b0;
      case (r_state)
        ST_FETCH: if (!IMEM_BUSYWAIT) r_ir <= INSTRUCTION;
        ST_DECODE: begin
          r_a           <= w_rdata_a;
          r_b           <= w_rdata_b;
          r_alu_op      <= w_alu_op;
          r_sub         <= w_sub;
          r_use_imm     <= w_use_imm;
          r_writes      <= w_writes;
          r_is_j        <= w_is_j;
          r_is_beq      <= w_is_beq;
          r_illegal_ins <= ~w_legal;
        end
        ST_EXECUTE: begin
          r_result  <= w_alu;
          r_eq      <= (r_a == r_b);
          r_target  <= w_target;
          r_illegal <= r_illegal_ins;
        end
        ST_WRITEBACK: begin
          r_pc <= (r_is_j | (r_is_beq & r_eq)) ? r_target : r_pc + 32'd4;
        end
        default: ;
      endcase
    end
  end

  assign w_we = (r_state == ST_WRITEBACK) & r_writes;

  reg_file_p #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
    .i_clk      (CLK),
    .i_reset    (RESET),
    .i_raddr_a  (REG_AW'(r_ir.rt)),
    .o_rdata_a  (w_rdata_a),
    .i_raddr_b  (REG_AW'(r_ir.rs)),
    .o_rdata_b  (w_rdata_b),
    .i_dbg_addr (DBG_ADDR),
    .o_dbg_data (DBG_DATA),
    .i_we       (w_we),
    .i_waddr    (REG_AW'(r_ir.rd)),
    .i_wdata    (r_result)
  );

  assign PC        = r_pc;
  assign IMEM_READ = r_imem_read;
  assign ILLEGAL   = r_illegal;

endmodule

// File: tb/tb_cpu_multicycle.sv
// Purpose: self-checking bench for cpu_multicycle (DATA_W=8, NREG=8).
// Ports:   none (top-level bench).
module tb_cpu_multicycle;

  localparam int K_PC = 0, K_CYC = 1, K_ILL = 2, K_RD = 3, K_ILLOUT = 4, K_REG = 5;
  localparam logic [31:0] GARB = 32'h0007_00AA;  // loadi r7,0xAA: visible if wrongly fetched

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] PC;
  logic        IMEM_READ;
  logic        IMEM_BUSYWAIT;
  logic [31:0] INSTRUCTION;
  logic        ILLEGAL;
  logic [2:0]  DBG_ADDR;
  logic [7:0]  DBG_DATA;

  always #5 CLK = ~CLK;

  cpu_multicycle #(.DATA_W(8), .NREG(8)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .PC            (PC),
    .IMEM_READ     (IMEM_READ),
    .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
    .INSTRUCTION   (INSTRUCTION),
    .ILLEGAL       (ILLEGAL),
    .DBG_ADDR      (DBG_ADDR),
    .DBG_DATA      (DBG_DATA)
  );

  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          g_cyc, g_ill;
  logic [7:0]  m_reg [8];
  logic [31:0] m_pc;

  function automatic void push(input string tag, input int kind, input int idx, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.kind = kind; e.idx = idx; e.val = val;
    sb.push_back(e);
  endfunction

  function automatic void push_regs(input string tag);
    for (int i = 0; i < 8; i++) push($sformatf("%s.r%0d", tag, i), K_REG, i, 32'(m_reg[i]));
  endfunction

  // Reference behaviour of one instruction; returns 1 if illegal.
  function automatic bit model(input logic [31:0] ins);
    logic [7:0]  op, rd, rt, rs, a, b;
    logic [31:0] nxt;
    bit          ill;
    op = ins[31:24]; rd = ins[23:16]; rt = ins[15:8]; rs = ins[7:0];
    a = m_reg[rt[2:0]]; b = m_reg[rs[2:0]];
    nxt = m_pc + 32'd4;
    ill = 1'b0;
    case (op)
      8'h00: begin ill = (rd > 8'd7); if (!ill) m_reg[rd[2:0]] = rs; end
      8'h01: begin ill = (rd > 8'd7) || (rs > 8'd7); if (!ill) m_reg[rd[2:0]] = b; end
      8'h02, 8'h03, 8'h04, 8'h05: begin
        ill = (rd > 8'd7) || (rt > 8'd7) || (rs > 8'd7);
        if (!ill) begin
          case (op)
            8'h02:   m_reg[rd[2:0]] = a + b;
            8'h03:   m_reg[rd[2:0]] = a - b;
            8'h04:   m_reg[rd[2:0]] = a & b;
            default: m_reg[rd[2:0]] = a | b;
          endcase
        end
      end
      8'h06: nxt = m_pc + 32'd4 + {{22{rd[7]}}, rd, 2'b00};
      8'h07: begin
        ill = (rt > 8'd7) || (rs > 8'd7);
        if (!ill && a == b) nxt = m_pc + 32'd4 + {{22{rd[7]}}, rd, 2'b00};
      end
      default: ill = 1'b1;
    endcase
    m_pc = nxt;
    return ill;
  endfunction

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_PC:     obs = PC;
        K_CYC:    obs = 32'(g_cyc);
        K_ILL:    obs = 32'(g_ill);
        K_RD:     obs = 32'(IMEM_READ);
        K_ILLOUT: obs = 32'(ILLEGAL);
        default: begin
          DBG_ADDR = 3'(e.idx);
          #1;
          obs = 32'(DBG_DATA);
        end
      endcase
      checks++;
      assert (obs === e.val)
        else begin
          errors++;
          $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
        end
    end
  endtask

  // Runs one instruction: align, stall `stalls` fetch cycles, deliver, wait for FETCH.
  task automatic exec(input logic [31:0] ins, input int stalls);
    logic [31:0] pc0;
    IMEM_BUSYWAIT = 1'b1;
    INSTRUCTION   = GARB;
    @(posedge CLK); #1;
    pc0   = PC;
    g_cyc = 0;
    g_ill = 0;
    for (int s = 0; s < stalls; s++) begin
      @(posedge CLK); #1;
      g_cyc++;
      checks++;
      assert (PC === pc0)
        else begin
          errors++;
          $error("FAIL stall_pc observed=%h expected=%h", PC, pc0);
        end
    end
    IMEM_BUSYWAIT = 1'b0;
    INSTRUCTION   = ins;
    @(posedge CLK); #1;
    g_cyc++;
    IMEM_BUSYWAIT = 1'b1;
    INSTRUCTION   = GARB;
    while (!IMEM_READ && g_cyc < 40) begin
      g_ill += int'(ILLEGAL);
      @(posedge CLK); #1;
      g_cyc++;
    end
    g_ill += int'(ILLEGAL);
  endtask

  task automatic run(input string tag, input logic [31:0] ins, input int stalls);
    bit ill;
    ill = model(ins);
    push({tag, ".pc"}, K_PC, 0, m_pc);
    push({tag, ".cycles"}, K_CYC, 0, 32'(4 + stalls));
    push({tag, ".illegal"}, K_ILL, 0, ill ? 32'd1 : 32'd0);
    push_regs(tag);
    exec(ins, stalls);
    drain();
  endtask

  task automatic do_reset(input string tag);
    RESET         = 1'b1;
    IMEM_BUSYWAIT = 1'b1;
    INSTRUCTION   = GARB;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    m_pc  = '0;
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    push({tag, ".pc"}, K_PC, 0, 32'h0);
    push({tag, ".imem_read"}, K_RD, 0, 32'h1);
    push({tag, ".illegal"}, K_ILLOUT, 0, 32'h0);
    push_regs(tag);
    drain();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET         = 1'b1;
    IMEM_BUSYWAIT = 1'b1;
    INSTRUCTION   = GARB;
    DBG_ADDR      = '0;

    do_reset("reset");

    // ALU ops, PC advancing by 4 per 4-cycle instruction
    run("loadi_r1", 32'h00_01_00_05, 0);
    run("loadi_r2", 32'h00_02_00_03, 0);
    run("sub_r3",   32'h03_03_01_02, 0);
    run("loadi_r4", 32'h00_04_00_FF, 0);
    run("loadi_r5", 32'h00_05_00_01, 0);
    run("add_r6",   32'h02_06_04_05, 0);
    run("loadi_f0", 32'h00_01_00_F0, 0);
    run("loadi_3c", 32'h00_02_00_3C, 0);
    run("and_r3",   32'h04_03_01_02, 0);
    run("or_r7",    32'h05_07_01_02, 0);

    // Branches
    do_reset("reset2");
    run("set_r1",   32'h00_01_00_07, 0);
    run("set_r2",   32'h00_02_00_07, 0);
    run("set_r3",   32'h00_03_00_09, 0);
    run("mov_r0",   32'h01_00_00_03, 0);
    run("beq_ne",   32'h07_02_01_03, 0);  // at 0x10 -> 0x14
    run("j_back",   32'h06_FE_00_00, 0);  // at 0x14 -> 0x10
    run("beq_eq",   32'h07_02_01_02, 0);  // at 0x10 -> 0x1C
    run("pad",      32'h00_06_00_80, 0);  // at 0x1C -> 0x20
    run("j_20",     32'h06_FE_00_00, 0);  // at 0x20 -> 0x1C

    // Fetch stalls
    run("busywait", 32'h00_05_00_42, 3);

    // Illegal instructions
    run("bad_op",   32'h09_01_01_01, 0);
    run("bad_rd",   32'h02_08_01_02, 0);

    // Backward jump at PC=0 wraps
    do_reset("reset3");
    run("j_wrap",   32'h06_FE_00_00, 0);

    // Reset during EXECUTE discards the pending write
    IMEM_BUSYWAIT = 1'b1;
    INSTRUCTION   = GARB;
    @(posedge CLK); #1;
    IMEM_BUSYWAIT = 1'b0;
    INSTRUCTION   = 32'h00_01_00_55;
    @(posedge CLK); #1;                 // DECODE
    IMEM_BUSYWAIT = 1'b1;
    INSTRUCTION   = GARB;
    @(posedge CLK); #1;                 // EXECUTE
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    m_pc  = '0;
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    push("midrst.pc", K_PC, 0, 32'h0);
    push("midrst.imem_read", K_RD, 0, 32'h1);
    push("midrst.illegal", K_ILLOUT, 0, 32'h0);
    push_regs("midrst");
    drain();
    run("after_rst", 32'h00_02_00_11, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_multicycle.md
# cpu_multicycle

Parametrised multi-cycle successor to the single-cycle 8-bit CPU core. It has configurable data width and register count, and a four-state fetch/decode/execute/writeback FSM. Instruction fetch uses a request/busywait handshake. It adds `j`, `beq` and illegal-instruction detection. It sits between the instruction memory controller and the testbench/debug harness, and replaces the flat `cpu` top.

## Interface
Parameters:
- `DATA_W`, 8: register/ALU width; 8..32.
- `NREG`, 8: number of general registers; power of two, 2..256.
- `REG_AW`, `$clog2(NREG)`: register index width; derived, not overridable.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RESET`  in  1  reset; one clock; reset is synchronous and active-high.
- `PC`  out  32  address of the instruction being fetched/executed.
- `IMEM_READ`  out  1  fetch request; high throughout FETCH.
- `IMEM_BUSYWAIT`  in  1  memory stall; `INSTRUCTION` is valid in a FETCH cycle where this is low.
- `INSTRUCTION`  in  32  fetched word.
- `ILLEGAL`  out  1  one-cycle pulse in WRITEBACK of an illegal instruction.
- `DBG_ADDR`  in  `REG_AW`  debug register select.
- `DBG_DATA`  out  `DATA_W`  combinational read of register `DBG_ADDR`.

## Operation
- Encoding: OP[31:24], RD/OFFSET[23:16], RT[15:8], RS/IMM[7:0].
- Opcodes:
  - 0x00 `loadi` RD = sext(IMM)
  - 0x01 `mov` RD = RS
  - 0x02 `add` RD = RT+RS
  - 0x03 `sub` RD = RT−RS (add of two's complement)
  - 0x04 `and`
  - 0x05 `or`
  - 0x06 `j`: PC = PC+4+(sext(OFFSET)<<2)
  - 0x07 `beq`: same target if RT==RS, else PC+4; no register write
- Arithmetic is modulo 2^DATA_W; no flags, no carry out.
- IMM is sign-extended from 8 bits to DATA_W. When DATA_W=8 it is used as is.
- Illegal instructions:
  - any other opcode;
  - any used register field with bits above `REG_AW` nonzero.
- An illegal instruction executes as a NOP (no register write, PC+4) and pulses `ILLEGAL`.
- FSM states:
  - FETCH: `IMEM_READ`=1. If `IMEM_BUSYWAIT`=0, latch `INSTRUCTION` into IR and go to DECODE; else stay.
  - DECODE: read RT/RS into operand registers A/B; classify the opcode.
  - EXECUTE: compute ALU result, branch-equal compare and branch target into internal registers.
  - WRITEBACK: write RD if the op writes; update `PC`; go to FETCH.
- Register r0 is an ordinary register (not hard-wired zero).

## Timing
- Reset values:
  - `PC`=0, state=FETCH, all registers=0, IR=0, `ILLEGAL`=0.
  - `IMEM_READ`=1 (state FETCH).
- Latency is 4 cycles per instruction plus one extra cycle per FETCH cycle with `IMEM_BUSYWAIT`=1.
- `PC` changes only on the WRITEBACK edge and is stable through FETCH stalls.
- The register write and the `PC` update happen on the same edge. The new value is visible on `DBG_DATA` the cycle after.
- The `beq` compare uses values read in DECODE. A write to the same register cannot be in flight, since there is no overlap.
- `RESET` in any state:
  - the next edge forces reset values;
  - any pending write is discarded;
  - `RESET` wins over a simultaneous WRITEBACK.
- PC arithmetic wraps modulo 2^32. A backward `j` at `PC`=0 wraps without error.
- `INSTRUCTION` is ignored outside FETCH and while busywait is high.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants;
  - the FSM state encoding (FETCH, DECODE, EXECUTE, WRITEBACK);
  - ALU op select constants (FWD, ADD, AND, OR);
  - the instruction field bit positions.
- One sub-module, `reg_file_p #(DATA_W, NREG)`: two combinational read ports plus a debug read port, one synchronous write port, synchronous clear on `RESET`.
- The ALU, negation and immediate mux stay inline in `cpu_multicycle`.

## Test plan
All scenarios use DATA_W=8, NREG=8, busywait low unless stated.
- Reset: hold `RESET` 2 cycles → `PC`=0, `IMEM_READ`=1, `ILLEGAL`=0, `DBG_DATA`=0 for all 8 addresses.
- ALU ops:
  - `loadi r1,0x05`; `loadi r2,0x03`; `sub r3,r1,r2` → r3=0x02.
  - `loadi r4,0xFF`; `loadi r5,0x01`; `add r6,r4,r5` → r6=0x00.
  - `and`/`or` of 0xF0,0x3C → 0x30/0xFC.
  - `PC` advances by 4 every 4 cycles.
- Branches:
  - `beq` at `PC`=0x10, r1==r2, OFFSET=0x02 → next `PC`=0x1C.
  - Same with r1≠r2 → 0x14.
  - `j` OFFSET=0xFE at 0x20 → 0x1C.
- Busywait: hold `IMEM_BUSYWAIT`=1 for 3 fetch cycles → `PC` unchanged, no register change, instruction completes in 7 cycles.
- Illegal:
  - opcode 0x09 → `ILLEGAL` high exactly 1 cycle, no register change, `PC`+4.
  - `add` with RD=0x08 → same response.
- Mid-operation reset: assert `RESET` during EXECUTE of `loadi r1,0x55` → r1 stays 0, `PC`=0, state FETCH on the next edge.
